// File: rtl/acc_proc_param_if.sv
// Instruction-stream handshake between an instruction source and the
// accumulator core. The core accepts an instruction on a rising edge
// where instr_valid && instr_ready.
interface acc_proc_param_if #(
    parameter int INSTR_W = 6
) ();
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;

    modport master (output instr, output instr_valid, input  instr_ready);
    modport slave  (input  instr, input  instr_valid, output instr_ready);
endinterface

// File: rtl/acc_proc_param.sv
// Parametrised accumulator processor: executes a valid/ready instruction
// stream against an accumulator, a small register file and the portin /
// portout ports. It has zero/carry flags, a DATA_W-cycle shift-add
// multiply that stalls the stream, and a HALT state left only by reset.
module acc_proc_param #(
    parameter int DATA_W = 4,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    acc_proc_param_if.slave   bus,
    input  logic [DATA_W-1:0] portin,
    output logic [DATA_W-1:0] portout,
    output logic              out_valid,
    output logic [DATA_W-1:0] acc,
    output logic              zero,
    output logic              carry,
    output logic              halted
);
    localparam int REG_AW  = $clog2(NREGS);
    localparam int INSTR_W = 4 + REG_AW;
    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_IN   = 4'h1, OP_OUT  = 4'h2, OP_LDR  = 4'h3,
        OP_STR  = 4'h4, OP_ADD  = 4'h5, OP_SUB  = 4'h6, OP_AND  = 4'h7,
        OP_OR   = 4'h8, OP_XOR  = 4'h9, OP_NOT  = 4'hA, OP_SHL  = 4'hB,
        OP_SHR  = 4'hC, OP_MUL  = 4'hD, OP_CLR  = 4'hE, OP_HALT = 4'hF
    } op_e;

    typedef enum logic [1:0] {S_RUN, S_MUL, S_HALT} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   regs [NREGS];

    // Multiplier working set: shifted multiplicand, remaining multiplier
    // bits and the running partial product.
    logic [2*DATA_W-1:0] mcand_q;
    logic [2*DATA_W-1:0] prod_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [CNT_W-1:0]    cnt_q;

    op_e                 op;
    logic [REG_AW-1:0]   r;
    logic                accept;
    logic                mul_last;
    logic [DATA_W-1:0]   reg_val;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] prod_final;

    logic [DATA_W-1:0]   acc_d;
    logic                carry_d;
    logic                acc_we;

    assign op       = op_e'(bus.instr[INSTR_W-1 -: 4]);
    assign r        = bus.instr[REG_AW-1:0];
    assign bus.instr_ready = rst_n && (state_q == S_RUN);
    assign accept   = bus.instr_valid && bus.instr_ready;
    assign mul_last = (state_q == S_MUL) && (cnt_q == MUL_LAST);
    assign halted   = (state_q == S_HALT);

    assign reg_val    = regs[r];
    assign sum        = {1'b0, acc} + {1'b0, reg_val};
    // The extra top bit of the difference is the borrow (reg > acc).
    assign diff       = {1'b0, acc} - {1'b0, reg_val};
    assign prod_final = prod_q + (mplier_q[0] ? mcand_q : '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RUN;
        else        state_q <= state_d;
    end

    // Next-state logic: MUL runs a fixed count, HALT is sticky.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (accept && op == OP_MUL)  state_d = S_MUL;
                if (accept && op == OP_HALT) state_d = S_HALT;
            end
            S_MUL:   if (mul_last) state_d = S_RUN;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RUN;
        endcase
    end

    // Accumulator / carry update for single-cycle ops and MUL completion.
    always_comb begin
        acc_d   = acc;
        carry_d = carry;
        acc_we  = 1'b0;
        if (mul_last) begin
            acc_d   = prod_final[DATA_W-1:0];
            carry_d = |prod_final[2*DATA_W-1:DATA_W];
            acc_we  = 1'b1;
        end else if (accept) begin
            case (op)
                OP_IN:  begin acc_d = portin;              acc_we = 1'b1; end
                OP_LDR: begin acc_d = reg_val;             acc_we = 1'b1; end
                OP_ADD: begin {carry_d, acc_d} = sum;      acc_we = 1'b1; end
                OP_SUB: begin {carry_d, acc_d} = diff;     acc_we = 1'b1; end
                OP_AND: begin acc_d = acc & reg_val;       acc_we = 1'b1; end
                OP_OR:  begin acc_d = acc | reg_val;       acc_we = 1'b1; end
                OP_XOR: begin acc_d = acc ^ reg_val;       acc_we = 1'b1; end
                OP_NOT: begin acc_d = ~acc;                acc_we = 1'b1; end
                OP_SHL: begin
                    carry_d = acc[DATA_W-1];
                    acc_d   = acc << 1;
                    acc_we  = 1'b1;
                end
                OP_SHR: begin
                    carry_d = acc[0];
                    acc_d   = acc >> 1;
                    acc_we  = 1'b1;
                end
                OP_CLR: begin acc_d = '0; carry_d = 1'b0;  acc_we = 1'b1; end
                default: ;
            endcase
        end
    end

    // Architectural datapath state: accumulator, flags, port, registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            portout   <= '0;
            out_valid <= 1'b0;
            // NOTE: the register file is architecturally cleared by reset, so it is a reset flop array rather than a RAM.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            acc       <= acc_d;
            carry     <= carry_d;
            if (acc_we) zero <= (acc_d == '0);
            out_valid <= accept && (op == OP_OUT);
            if (accept && op == OP_OUT) portout <= acc;
            if (accept && op == OP_STR) regs[r] <= acc;
        end
    end

    // Shift-add multiplier: snapshot operands at accept, one bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (accept && op == OP_MUL) begin
            mcand_q  <= {{DATA_W{1'b0}}, acc};
            mplier_q <= reg_val;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else if (state_q == S_MUL) begin
            prod_q   <= prod_final;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_acc_proc_param.sv
// Directed bench for acc_proc_param (DATA_W=4, NREGS=4). Expected portout
// values are queued when an OUT is issued; a monitor pops one per out_valid
// cycle. Accumulator and flag state is checked directly after each step.
module tb_acc_proc_param;
    localparam logic [3:0] OP_NOP = 4'h0, OP_IN = 4'h1, OP_OUT = 4'h2, OP_LDR = 4'h3,
                           OP_STR = 4'h4, OP_ADD = 4'h5, OP_SUB = 4'h6, OP_XOR = 4'h9,
                           OP_NOT = 4'hA, OP_SHL = 4'hB, OP_SHR = 4'hC, OP_MUL = 4'hD,
                           OP_CLR = 4'hE, OP_HALT = 4'hF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] portin = '0;
    logic [3:0] portout, acc;
    logic       out_valid, zero, carry, halted;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] sb_q [$];

    acc_proc_param_if #(.INSTR_W(6)) bus ();

    acc_proc_param #(.DATA_W(4), .NREGS(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .portin(portin),
        .portout(portout), .out_valid(out_valid), .acc(acc),
        .zero(zero), .carry(carry), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: one expected portout per out_valid cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out_valid: got portout %0h expected no pulse", portout);
            end else begin
                check("portout", 8'(portout), 8'(sb_q.pop_front()));
            end
        end
    end

    // Present an instruction and hold it until the core accepts it.
    task automatic issue(input logic [3:0] op, input logic [1:0] r);
        int waited = 0;
        bus.instr = {op, r};
        bus.instr_valid = 1'b1;
        @(negedge clk);
        while (!bus.instr_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.instr_ready) check("accept_timeout", 8'd0, 8'd1);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic do_in(input logic [3:0] v);
        portin = v;
        issue(OP_IN, 2'd0);
    endtask

    task automatic do_out(input logic [3:0] expected);
        sb_q.push_back(expected);
        issue(OP_OUT, 2'd0);
    endtask

    task automatic wait_ready();
        int waited = 0;
        @(negedge clk);
        while (!bus.instr_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.instr_ready) check("ready_timeout", 8'd0, 8'd1);
    endtask

    task automatic check_state(input string tag, input logic [3:0] e_acc, input logic e_zero, input logic e_carry);
        check({tag, "_acc"},   8'(acc),   8'(e_acc));
        check({tag, "_zero"},  8'(zero),  8'(e_zero));
        check({tag, "_carry"}, 8'(carry), 8'(e_carry));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy;
        int ov_seen;
        bus.instr = '0;
        bus.instr_valid = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_state("rst", 4'h0, 1'b0, 1'b0);
        check("rst_portout", 8'(portout), 8'h0);
        check("rst_out_valid", 8'(out_valid), 8'h0);
        check("rst_halted", 8'(halted), 8'h0);
        check("rst_ready", 8'(bus.instr_ready), 8'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_ready", 8'(bus.instr_ready), 8'h1);
        check("rel_halted", 8'(halted), 8'h0);

        // Basic datapath: 3 + 1 = 4, with a single-cycle out_valid pulse.
        do_in(4'h3);
        issue(OP_STR, 2'd1);
        do_in(4'h1);
        issue(OP_ADD, 2'd1);
        check_state("add", 4'h4, 1'b0, 1'b0);
        do_out(4'h4);
        check("ov_pulse_hi", 8'(out_valid), 8'h1);
        @(negedge clk);
        @(negedge clk);
        check("ov_pulse_lo", 8'(out_valid), 8'h0);

        // Wrap-around and borrow.
        do_in(4'hF);
        issue(OP_STR, 2'd0);
        do_in(4'h1);
        issue(OP_ADD, 2'd0);
        check_state("wrap", 4'h0, 1'b1, 1'b1);
        issue(OP_SUB, 2'd0);
        check_state("borrow", 4'h1, 1'b0, 1'b1);

        // Multiply 5*3 with an OUT held valid through the busy period.
        do_in(4'h3);
        issue(OP_STR, 2'd2);
        do_in(4'h5);
        issue(OP_MUL, 2'd2);
        bus.instr = {OP_OUT, 2'd0};
        bus.instr_valid = 1'b1;
        busy = 0;
        @(negedge clk);
        while (!bus.instr_ready && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        check("mul_busy_cycles", 8'(busy), 8'd4);
        sb_q.push_back(4'hF);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        check_state("mul15", 4'hF, 1'b0, 1'b0);

        // Multiply 6*3 = 18: low nibble 2, high half nonzero.
        do_in(4'h6);
        issue(OP_MUL, 2'd2);
        wait_ready();
        check_state("mul18", 4'h2, 1'b0, 1'b1);

        // Store then immediately use the same register.
        issue(OP_STR, 2'd3);
        issue(OP_ADD, 2'd3);
        check_state("str_fwd", 4'h4, 1'b0, 1'b0);

        // Unary ops and logic.
        issue(OP_NOT, 2'd0);
        check_state("not", 4'hB, 1'b0, 1'b0);
        issue(OP_SHL, 2'd0);
        check_state("shl", 4'h6, 1'b0, 1'b1);
        issue(OP_SHR, 2'd0);
        check_state("shr", 4'h3, 1'b0, 1'b0);
        issue(OP_XOR, 2'd3);
        check_state("xor", 4'h1, 1'b0, 1'b0);
        issue(OP_LDR, 2'd1);
        check_state("ldr", 4'h3, 1'b0, 1'b0);
        issue(OP_NOP, 2'd0);
        check_state("nop", 4'h3, 1'b0, 1'b0);
        issue(OP_CLR, 2'd0);
        check_state("clr", 4'h0, 1'b1, 1'b0);

        // Back-to-back OUTs keep out_valid high for two cycles.
        do_in(4'h9);
        do_out(4'h9);
        do_out(4'h9);
        check("b2b_ov_hi", 8'(out_valid), 8'h1);
        @(negedge clk);
        @(negedge clk);
        check("b2b_ov_lo", 8'(out_valid), 8'h0);

        // Reset in the second busy cycle of a multiply.
        do_in(4'h5);
        issue(OP_MUL, 2'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_state("rstmul", 4'h0, 1'b0, 1'b0);
        check("rstmul_ready", 8'(bus.instr_ready), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rstmul_no_partial", 8'(acc), 8'h0);
        check("rstmul_ready_rel", 8'(bus.instr_ready), 8'h1);
        do_in(4'h7);
        issue(OP_LDR, 2'd2);
        check_state("rstmul_reg", 4'h0, 1'b1, 1'b0);

        // HALT: later IN/OUT must have no effect.
        do_in(4'h5);
        do_out(4'h5);
        issue(OP_HALT, 2'd0);
        check("halt_flag", 8'(halted), 8'h1);
        check("halt_ready", 8'(bus.instr_ready), 8'h0);
        portin = 4'hA;
        ov_seen = 0;
        bus.instr = {OP_IN, 2'd0};
        bus.instr_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        bus.instr = {OP_OUT, 2'd0};
        repeat (5) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        bus.instr_valid = 1'b0;
        check("halt_acc", 8'(acc), 8'h5);
        check("halt_portout", 8'(portout), 8'h5);
        check("halt_out_valid_cycles", 8'(ov_seen), 8'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("halt_cleared", 8'(halted), 8'h0);
        check("halt_rst_ready", 8'(bus.instr_ready), 8'h1);

        check("sb_drained", 8'(sb_q.size()), 8'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/acc_proc_param.md
Name: acc_proc_param

Overview:
Parametrised accumulator processor. It is the next generation of the 4-bit Control core, generalised in data width and register-file depth. It accepts a stream of instructions through a valid/ready handshake and executes them against an accumulator, a register file and the portin/portout ports. New over the previous core: zero/carry flags, a multi-cycle multiply with backpressure, an output-valid strobe and a HALT state.

Parameters:
DATA_W, 4, accumulator/register/port width (>=2)
NREGS, 4, register-file entries (power of two, >=2); localparam REG_AW = clog2(NREGS)
INSTR_W (localparam), 4+REG_AW, instruction width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
portin  input  DATA_W  external data input
instr  input  INSTR_W  [INSTR_W-1 -: 4]=opcode, [REG_AW-1:0]=register index r
instr_valid  input  1  instr presented
instr_ready  output  1  core can accept instr this cycle
portout  output  DATA_W  registered output port
out_valid  output  1  one-cycle pulse when portout written
acc  output  DATA_W  accumulator (observability)
zero  output  1  acc==0 after last acc write
carry  output  1  carry/borrow/overflow of last arithmetic op
halted  output  1  core in HALT

Behaviour:
- Reset (async assert, sync release): acc, portout, all registers, zero, carry, out_valid, halted = 0. State = RUN. instr_ready = 0 while rst_n low.
- States:
  - RUN: instr_ready=1.
  - MUL: instr_ready=0.
  - HALT: instr_ready=0, halted=1.
- Accept: instruction accepted at rising edge when instr_valid && instr_ready. Single-cycle ops update state at that edge; results are visible the following cycle. An instruction held while instr_ready=0 is not consumed.
- Opcodes:
  - 0000 NOP
  - 0001 IN: acc<=portin
  - 0010 OUT: portout<=acc, out_valid=1 for exactly the next cycle
  - 0011 LDR: acc<=reg[r]
  - 0100 STR: reg[r]<=acc; flags unchanged
  - 0101 ADD: {carry,acc}<=acc+reg[r]
  - 0110 SUB: acc<=acc-reg[r]; carry=1 if borrow (reg[r]>acc)
  - 0111 AND, 1000 OR, 1001 XOR: with reg[r]; carry unchanged
  - 1010 NOT: acc<=~acc
  - 1011 SHL: carry<=acc[MSB], acc<<1
  - 1100 SHR: carry<=acc[0], acc>>1 (logical)
  - 1101 MUL: enter MUL; shift-add over exactly DATA_W cycles using snapshots of acc and reg[r] taken at accept. On the last cycle acc<=low DATA_W bits of the product, carry<=(high half !=0), state returns to RUN. instr_ready is therefore low for DATA_W cycles after accept.
  - 1110 CLR: acc<=0, carry<=0
  - 1111 HALT: enter HALT; only reset exits.
- zero: recomputed on every acc write (IN, LDR, ALU, NOT, shifts, MUL, CLR); held otherwise.
- Wrap-around: all arithmetic is modulo 2^DATA_W; carry captures the excess.
- out_valid: deasserts the cycle after OUT unless another OUT is accepted back-to-back, in which case it stays high and portout updates every cycle.
- STR then LDR/ALU of the same register in consecutive cycles uses the newly stored value (no hazard; register write occurs at the STR edge).
- Reset mid-MUL or in HALT: abort immediately; all state returns to reset values; no partial product is written.

Test Plan (DATA_W=4, NREGS=4):
- Reset: rst_n low 2 cycles -> all outputs 0, instr_ready=0; after release instr_ready=1, halted=0.
- Basic datapath: portin=0011 IN; STR r1; portin=0001 IN; ADD r1; OUT -> acc=0100, portout=0100, out_valid high exactly 1 cycle, zero=0, carry=0.
- Flags and wrap: portin=1111 IN; STR r0; portin=0001 IN; ADD r0 -> acc=0000, zero=1, carry=1. Then SUB r0 -> acc=0001, carry=1 (borrow), zero=0.
- Multiply:
  - IN 0011; STR r2; IN 0101; MUL r2 -> instr_ready low exactly 4 cycles; OUT held valid meanwhile is not taken until ready rises; acc=1111, carry=0.
  - IN 0110; MUL r2 -> acc=0010, carry=1.
- Reset mid-MUL: drop rst_n in 2nd busy cycle -> acc=0, carry=0, registers=0. After release, state=RUN, instr_ready=1.
- HALT: HALT accepted -> halted=1, instr_ready=0; subsequent IN/OUT with instr_valid=1 for 5 cycles leave acc/portout unchanged and out_valid=0. Reset clears halted.
